// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared defaults and decode/ALU encodings             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } itype_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_sb_if : issue, operand and writeback bundle of regfile_sb  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);
  localparam int AW = addr_width(NREGS);

  logic                iss_valid_i;
  logic                iss_ready_o;
  logic [NRD*AW-1:0]   iss_rs_i;
  logic [AW-1:0]       iss_rd_i;
  logic                iss_wen_i;
  logic                opr_valid_o;
  logic                opr_ready_i;
  logic [NRD*XLEN-1:0] opr_data_o;
  logic                wb_valid_i;
  logic [AW-1:0]       wb_addr_i;
  logic [XLEN-1:0]     wb_data_i;
  logic                err_o;

  modport master (
    output iss_valid_i, iss_rs_i, iss_rd_i, iss_wen_i, opr_ready_i,
           wb_valid_i, wb_addr_i, wb_data_i,
    input  iss_ready_o, opr_valid_o, opr_data_o, err_o
  );

  modport slave (
    input  iss_valid_i, iss_rs_i, iss_rd_i, iss_wen_i, opr_ready_i,
           wb_valid_i, wb_addr_i, wb_data_i,
    output iss_ready_o, opr_valid_o, opr_data_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_scoreboard : busy bits with set-wins priority, hazard check|
// | Option macro: REGFILE_BYPASS_EN.  Rev 1.0                          |
// +--------------------------------------------------------------------+
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [AW-1:0]     rd_i,
  input  logic              wen_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NRD*AW-1:0] rs_i,
  output logic              haz_o,
  output logic              clr_nobusy_o
);
  logic [NREGS-1:0] busy_q, busy_d, busy_view;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy_view = busy_q;
`ifdef REGFILE_BYPASS_EN
    if (clr_en_i) busy_view[clr_addr_i] = 1'b0;
`endif
  end

  always_comb begin
    haz_o = wen_i && busy_view[rd_i];
    for (int k = 0; k < NRD; k++) begin
      if (busy_view[rs_i[k*AW +: AW]]) haz_o = 1'b1;
    end
  end

  assign clr_nobusy_o = clr_en_i && (clr_addr_i != '0) && !busy_q[clr_addr_i];

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_sb : register file + hazard scoreboard + operand slot      |
// | Option macro: REGFILE_BYPASS_EN.  Rev 1.0                          |
// +--------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int AW = addr_width(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NRD*XLEN-1:0] opr_data_q, opr_data_d, rd_data;
  logic                opr_valid_q, opr_valid_d;
  logic                err_q, err_d;
  logic                haz, wb_nobusy, slot_free, accept, set_en;

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .set_en_i     (set_en),
    .rd_i         (bus.iss_rd_i),
    .wen_i        (bus.iss_wen_i),
    .clr_en_i     (bus.wb_valid_i),
    .clr_addr_i   (bus.wb_addr_i),
    .rs_i         (bus.iss_rs_i),
    .haz_o        (haz),
    .clr_nobusy_o (wb_nobusy)
  );

  assign slot_free       = !opr_valid_q || bus.opr_ready_i;
  assign accept          = bus.iss_valid_i && !haz && slot_free;
  assign set_en          = accept && bus.iss_wen_i;
  assign bus.iss_ready_o = accept;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rs;
    logic [XLEN-1:0] val;
    assign rs = bus.iss_rs_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign val = (rs == '0) ? '0 :
                 (bus.wb_valid_i && (bus.wb_addr_i == rs)) ? bus.wb_data_i : regs_q[rs];
`else
    assign val = (rs == '0) ? '0 : regs_q[rs];
`endif
    assign rd_data[k*XLEN +: XLEN] = val;
  end

  always_comb begin
    opr_valid_d = opr_valid_q;
    opr_data_d  = opr_data_q;
    if (accept) begin
      opr_valid_d = 1'b1;
      opr_data_d  = rd_data;
    end else if (bus.opr_ready_i) begin
      opr_valid_d = 1'b0;
    end
    err_d = err_q | wb_nobusy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opr_valid_q <= 1'b0;
      opr_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      opr_valid_q <= opr_valid_d;
      opr_data_q  <= opr_data_d;
      err_q       <= err_d;
    end
  end

  // Entry 0 is cleared on reset and never written, so it reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.wb_valid_i && (bus.wb_addr_i != '0)) begin
      regs_q[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  assign bus.opr_valid_o = opr_valid_q;
  assign bus.opr_data_o  = opr_data_q;
  assign bus.err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_sb : directed vectors plus per-cycle reference model    |
// | Option macro: REGFILE_BYPASS_EN.  Rev 1.0                          |
// +--------------------------------------------------------------------+
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers, busy set, one operand slot.
  logic [XLEN-1:0]     m_regs [NREGS];
  bit                  m_busy [NREGS];
  bit                  m_valid, m_err, m_on;
  logic [NRD*XLEN-1:0] m_data, m_ops;
  bit                  m_haz, m_rdy, m_fwd;
  int                  m_r;

  initial m_on = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_data  = '0;
      m_on    = 1'b1;
    end else if (m_on) begin
      m_haz = 1'b0;
      for (int k = 0; k < NRD; k++) begin
        m_r   = int'(bus.iss_rs_i[k*AW +: AW]);
        m_fwd = BYP && bus.wb_valid_i && (int'(bus.wb_addr_i) == m_r) && (m_r != 0);
        if (m_busy[m_r] && !m_fwd) m_haz = 1'b1;
        m_ops[k*XLEN +: XLEN] = (m_r == 0) ? '0 : (m_fwd ? bus.wb_data_i : m_regs[m_r]);
      end
      m_r   = int'(bus.iss_rd_i);
      m_fwd = BYP && bus.wb_valid_i && (int'(bus.wb_addr_i) == m_r);
      if (bus.iss_wen_i && m_busy[m_r] && !m_fwd) m_haz = 1'b1;
      m_rdy = bus.iss_valid_i && !m_haz && (!m_valid || bus.opr_ready_i);

      chk("m_iss_ready", {63'd0, bus.iss_ready_o}, {63'd0, m_rdy});
      chk("m_opr_valid", {63'd0, bus.opr_valid_o}, {63'd0, m_valid});
      chk("m_opr_data",  64'(bus.opr_data_o), 64'(m_data));
      chk("m_err",       {63'd0, bus.err_o},       {63'd0, m_err});

      if (m_rdy) begin
        m_valid = 1'b1;
        m_data  = m_ops;
      end else if (bus.opr_ready_i) begin
        m_valid = 1'b0;
      end
      if (bus.wb_valid_i && bus.wb_addr_i != '0) begin
        if (!m_busy[bus.wb_addr_i]) m_err = 1'b1;
        m_regs[bus.wb_addr_i] = bus.wb_data_i;
        m_busy[bus.wb_addr_i] = 1'b0;
      end
      if (m_rdy && bus.iss_wen_i && bus.iss_rd_i != '0) m_busy[bus.iss_rd_i] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v, input int rs0, input int rs1, input int rd, input bit wen);
    bus.iss_valid_i = v;
    bus.iss_rs_i    = {AW'(rs1), AW'(rs0)};
    bus.iss_rd_i    = AW'(rd);
    bus.iss_wen_i   = wen;
  endtask

  task automatic wb(input bit v, input int addr, input logic [XLEN-1:0] data);
    bus.wb_valid_i = v;
    bus.wb_addr_i  = AW'(addr);
    bus.wb_data_i  = data;
  endtask

  initial begin
    reset = 1'b1;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, '0);
    bus.opr_ready_i = 1'b1;
    step(); step();
    reset = 1'b0;
    #2;
    chk("rst_valid", {63'd0, bus.opr_valid_o}, 64'd0);
    chk("rst_data",  64'(bus.opr_data_o), 64'd0);
    chk("rst_err",   {63'd0, bus.err_o}, 64'd0);

    step(); issue(1, 1, 2, 3, 1); #2;
    chk("t1_ready", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(1, 3, 0, 0, 0); #2;
    chk("t1_valid", {63'd0, bus.opr_valid_o}, 64'd1);
    chk("t1_data",  64'(bus.opr_data_o), 64'd0);
    chk("t1_busy3", {63'd0, bus.iss_ready_o}, 64'd0);

    step(); wb(1, 3, 32'hDEADBEEF); #2;
    chk("t2_wb_ready", {63'd0, bus.iss_ready_o}, {63'd0, BYP});
    step(); wb(0, 0, '0); #2;
    chk("t2_after_ready", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(0, 0, 0, 0, 0); #2;
    chk("t2_data", 64'(bus.opr_data_o), 64'h00000000_DEADBEEF);

    step(); issue(1, 0, 0, 5, 1); #2;
    chk("t3_set5", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(1, 5, 1, 0, 0); #2;
    chk("t3_raw_a", {63'd0, bus.iss_ready_o}, 64'd0);
    step(); #2;
    chk("t3_raw_b", {63'd0, bus.iss_ready_o}, 64'd0);
    step(); wb(1, 5, 32'h12345678); #2;
    chk("t3_wb_ready", {63'd0, bus.iss_ready_o}, {63'd0, BYP});
    step(); wb(0, 0, '0); #2;
    chk("t3_after_ready", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(0, 0, 0, 0, 0); #2;
    chk("t3_data", 64'(bus.opr_data_o), 64'h00000000_12345678);

    step(); bus.opr_ready_i = 1'b0; issue(1, 3, 5, 0, 0); #2;
    chk("t4_first", {63'd0, bus.iss_ready_o}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(); issue(1, 3, 0, 0, 0); #2;
      chk("t4_stall_ready", {63'd0, bus.iss_ready_o}, 64'd0);
      chk("t4_stall_valid", {63'd0, bus.opr_valid_o}, 64'd1);
      chk("t4_stall_data",  64'(bus.opr_data_o), 64'h12345678_DEADBEEF);
    end
    step(); bus.opr_ready_i = 1'b1; #2;
    chk("t4_release", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(0, 0, 0, 0, 0); #2;
    chk("t4_second", 64'(bus.opr_data_o), 64'h00000000_DEADBEEF);
    step(); #2;
    chk("t4_drop_valid", {63'd0, bus.opr_valid_o}, 64'd0);
    chk("t4_hold_data",  64'(bus.opr_data_o), 64'h00000000_DEADBEEF);

    step(); issue(1, 0, 0, 0, 1); wb(1, 0, 32'h55); #2;
    chk("t5_x0_a", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); wb(0, 0, '0); #2;
    chk("t5_x0_b", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(0, 0, 0, 0, 0); #2;
    chk("t5_data", 64'(bus.opr_data_o), 64'd0);
    chk("t5_err",  {63'd0, bus.err_o}, 64'd0);

    step(); wb(1, 7, 32'hA5A5A5A5); #2;
    step(); wb(0, 0, '0); issue(1, 7, 0, 9, 1); #2;
    chk("t6_err", {63'd0, bus.err_o}, 64'd1);
    chk("t6_ready", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(1, 9, 0, 0, 0); #2;
    chk("t6_data", 64'(bus.opr_data_o), 64'h00000000_A5A5A5A5);
    chk("t6_busy9", {63'd0, bus.iss_ready_o}, 64'd0);
    step(); reset = 1'b1; issue(0, 0, 0, 0, 0); #2;
    step(); reset = 1'b0; #2;
    chk("t6_rst_err",   {63'd0, bus.err_o}, 64'd0);
    chk("t6_rst_valid", {63'd0, bus.opr_valid_o}, 64'd0);
    chk("t6_rst_data",  64'(bus.opr_data_o), 64'd0);
    issue(1, 9, 7, 0, 0); #1;
    chk("t6_rst_busy", {63'd0, bus.iss_ready_o}, 64'd1);
    step(); issue(0, 0, 0, 0, 0); #2;
    chk("t6_rst_regs", 64'(bus.opr_data_o), 64'd0);
    chk("t6_rst_v2", {63'd0, bus.opr_valid_o}, 64'd1);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
